ula_sequenciador: RTL and testbench

- Operator-side driver for the 8-bit ALU. It is the initiator that feeds operands and opcode into the ALU and consumes the ALU's 8-bit result and 3-bit flag code.
- Operands A and B and the 3-bit opcode are loaded one at a time from board switches, each on a confirm-button press. The block then drives a stable operand set into the ALU, waits a settle interval, and captures the result and flags.
- The captured flag code is decoded into one-hot status LEDs for the board top level.

---
 rtl/ula_sequenciador_pkg.sv | 44 ++++
 rtl/detector_borda_botao.sv | 59 +++++
 rtl/ula_sequenciador.sv | 103 ++++++++++
 tb/tb_ula_sequenciador.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_sequenciador_pkg.sv
// Shared definitions for the ALU operator sequencer: FSM state codes,
// ALU flag codes and the flag-to-LED decode.
package ula_pkg;

   typedef enum logic [2:0] {
      CARREGA_A  = 3'd0,
      CARREGA_B  = 3'd1,
      CARREGA_OP = 3'd2,
      EXEC       = 3'd3,
      MOSTRA     = 3'd4
   } estado_t;

   // Flag codes as produced by the ALU; the ALU must use these same values.
   localparam logic [2:0] FLAG_NENHUM   = 3'b000;
   localparam logic [2:0] FLAG_ZERO     = 3'b001;
   localparam logic [2:0] FLAG_CARRY    = 3'b010;
   localparam logic [2:0] FLAG_ERRO     = 3'b100;
   localparam logic [2:0] FLAG_NADA     = 3'b110;
   localparam logic [2:0] FLAG_OVERFLOW = 3'b111;

   typedef struct packed {
      logic zero;
      logic carry;
      logic erro;
      logic overflow;
   } leds_t;

   // Undefined codes (011, 101) light Erro so a bad ALU response is visible.
   function automatic leds_t decodifica_flags(input logic [2:0] f);
      leds_t l;
      l = '0;
      case (f)
         FLAG_NENHUM,
         FLAG_NADA:     l = '0;
         FLAG_ZERO:     l.zero = 1'b1;
         FLAG_CARRY:    l.carry = 1'b1;
         FLAG_ERRO:     l.erro = 1'b1;
         FLAG_OVERFLOW: l.overflow = 1'b1;
         default:       l.erro = 1'b1;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/detector_borda_botao.sv
// Button front end: input register(s), optional debounce filter
// (macro ULA_SEQ_DEBOUNCE_EN) and a one-cycle rising-edge pulse.
module detector_borda_botao #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic Clock_in,
   input  logic Reset_in,
   input  logic Botao_in,
   output logic Pulso_out
);

`ifdef ULA_SEQ_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync2_q, filt_q, prev_q;
   logic [CW-1:0] cnt_q;

   // Two-flop synchronizer, then the filtered level only follows after a run of equal samples.
   always_ff @(posedge Clock_in) begin
      if (Reset_in) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         filt_q  <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= Botao_in;
         sync2_q <= sync1_q;
         prev_q  <= filt_q;
         if (sync2_q == filt_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            filt_q <= sync2_q;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign Pulso_out = filt_q & ~prev_q;
`else
   logic btn_q, prev_q;

   // Single register stage plus the delayed copy used for edge detection.
   always_ff @(posedge Clock_in) begin
      if (Reset_in) begin
         btn_q  <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         btn_q  <= Botao_in;
         prev_q <= btn_q;
      end
   end

   assign Pulso_out = btn_q & ~prev_q;
`endif

endmodule

// File: rtl/ula_sequenciador.sv
// Operator-side ALU driver: loads A, B and opcode on button presses, holds
// them stable for SETTLE_CYCLES, captures result/flags and lights the LEDs.
// Optional button debounce is enabled with macro ULA_SEQ_DEBOUNCE_EN.
module ula_sequenciador
   import ula_pkg::*;
#(
   parameter int SETTLE_CYCLES   = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       Clock_in,
   input  logic       Reset_in,
   input  logic [7:0] Chaves_in,
   input  logic       Carry_Chave_in,
   input  logic       Botao_in,
   output logic [7:0] A_out,
   output logic [7:0] B_out,
   output logic       C_out,
   output logic [2:0] Operacao_out,
   input  logic [7:0] Ula_Saida_in,
   input  logic [2:0] Ula_Flags_in,
   output logic [7:0] Resultado_out,
   output logic       Led_Zero_out,
   output logic       Led_Carry_out,
   output logic       Led_Erro_out,
   output logic       Led_Overflow_out,
   output logic       Valido_out,
   output logic [2:0] Estado_out
);

   estado_t    estado_q;
   logic [7:0] a_q, b_q, res_q;
   logic       c_q, valido_q;
   logic [2:0] op_q;
   logic [3:0] cnt_q;
   leds_t      leds_q;
   logic       pulso;

   detector_borda_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_botao (
      .Clock_in  (Clock_in),
      .Reset_in  (Reset_in),
      .Botao_in  (Botao_in),
      .Pulso_out (pulso)
   );

   // Sequencer FSM; every output is a register so the ALU inputs only move on load edges.
   always_ff @(posedge Clock_in) begin
      if (Reset_in) begin
         estado_q <= CARREGA_A;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= 1'b0;
         op_q     <= '0;
         res_q    <= '0;
         leds_q   <= '0;
         valido_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (estado_q)
            CARREGA_A: if (pulso) begin
               a_q      <= Chaves_in;
               valido_q <= 1'b0;
               leds_q   <= '0;
               estado_q <= CARREGA_B;
            end
            CARREGA_B: if (pulso) begin
               b_q      <= Chaves_in;
               estado_q <= CARREGA_OP;
            end
            CARREGA_OP: if (pulso) begin
               op_q     <= Chaves_in[2:0];
               c_q      <= Carry_Chave_in;
               cnt_q    <= '0;
               estado_q <= EXEC;
            end
            EXEC: begin
               if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
                  res_q    <= Ula_Saida_in;
                  leds_q   <= decodifica_flags(Ula_Flags_in);
                  valido_q <= 1'b1;
                  estado_q <= MOSTRA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            MOSTRA: if (pulso) estado_q <= CARREGA_A;
            default: estado_q <= CARREGA_A;
         endcase
      end
   end

   assign A_out            = a_q;
   assign B_out            = b_q;
   assign C_out            = c_q;
   assign Operacao_out     = op_q;
   assign Resultado_out    = res_q;
   assign Led_Zero_out     = leds_q.zero;
   assign Led_Carry_out    = leds_q.carry;
   assign Led_Erro_out     = leds_q.erro;
   assign Led_Overflow_out = leds_q.overflow;
   assign Valido_out       = valido_q;
   assign Estado_out       = estado_q;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench for ula_sequenciador (default SETTLE_CYCLES=2). Honours
// ULA_SEQ_DEBOUNCE_EN when compiled with it.
module tb_ula_sequenciador;

   localparam int DEB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] chaves = '0;
   logic       carry = 1'b0;
   logic       botao = 1'b0;
   logic [7:0] a_o, b_o, res_o, ula_saida = '0;
   logic       c_o, lz, lc, le, lo, valido;
   logic [2:0] op_o, estado, ula_flags = '0;

   int tests = 0;
   int fails = 0;

   ula_sequenciador #(.SETTLE_CYCLES(2), .DEBOUNCE_CYCLES(DEB)) dut (
      .Clock_in         (clk),
      .Reset_in         (rst),
      .Chaves_in        (chaves),
      .Carry_Chave_in   (carry),
      .Botao_in         (botao),
      .A_out            (a_o),
      .B_out            (b_o),
      .C_out            (c_o),
      .Operacao_out     (op_o),
      .Ula_Saida_in     (ula_saida),
      .Ula_Flags_in     (ula_flags),
      .Resultado_out    (res_o),
      .Led_Zero_out     (lz),
      .Led_Carry_out    (lc),
      .Led_Erro_out     (le),
      .Led_Overflow_out (lo),
      .Valido_out       (valido),
      .Estado_out       (estado)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press();
`ifdef ULA_SEQ_DEBOUNCE_EN
      botao = 1'b1;
      repeat (DEB + 4) tick();
      botao = 1'b0;
      repeat (DEB + 4) tick();
`else
      botao = 1'b1;
      tick();
      tick();
      botao = 1'b0;
      tick();
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tests++;
      if (estado !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", estado); end
      tests++;
      if ({a_o, b_o, c_o, op_o, res_o, lz, lc, le, lo, valido} !== 32'h0) begin
         fails++;
         $display("FAIL reset_outputs got A=%h B=%h C=%b Op=%h R=%h leds=%b%b%b%b V=%b exp all 0",
                  a_o, b_o, c_o, op_o, res_o, lz, lc, le, lo, valido);
      end
   endtask

   task automatic test_load_capture();
      ula_saida = 8'h3F;
      ula_flags = 3'b000;
      chaves = 8'h2A;
      press();
      tests++;
      if (estado !== 3'd1 || a_o !== 8'h2A) begin fails++; $display("FAIL load_a got st=%0d A=%h exp st=1 A=2a", estado, a_o); end
      chaves = 8'h15;
      press();
      tests++;
      if (estado !== 3'd2 || b_o !== 8'h15) begin fails++; $display("FAIL load_b got st=%0d B=%h exp st=2 B=15", estado, b_o); end
      chaves = 8'h03;
      carry = 1'b1;
`ifdef ULA_SEQ_DEBOUNCE_EN
      press();
      tick();
`else
      botao = 1'b1;
      tick();
      tests++;
      if (estado !== 3'd2) begin fails++; $display("FAIL op_latency got st=%0d exp 2", estado); end
      tick();
      tests++;
      if (estado !== 3'd3 || op_o !== 3'd3 || c_o !== 1'b1 || valido !== 1'b0) begin
         fails++; $display("FAIL exec_entry got st=%0d op=%0d c=%b v=%b exp st=3 op=3 c=1 v=0", estado, op_o, c_o, valido);
      end
      botao = 1'b0;
      chaves = 8'hEE;
      tick();
      tests++;
      if (estado !== 3'd3 || valido !== 1'b0 || op_o !== 3'd3 || a_o !== 8'h2A) begin
         fails++; $display("FAIL exec_hold got st=%0d v=%b op=%0d A=%h exp st=3 v=0 op=3 A=2a", estado, valido, op_o, a_o);
      end
      tick();
`endif
      tests++;
      if (estado !== 3'd4 || res_o !== 8'h3F || valido !== 1'b1 || {lz, lc, le, lo} !== 4'b0000) begin
         fails++; $display("FAIL capture got st=%0d R=%h v=%b leds=%b%b%b%b exp st=4 R=3f v=1 leds=0000",
                           estado, res_o, valido, lz, lc, le, lo);
      end
      tests++;
      if (a_o !== 8'h2A || b_o !== 8'h15 || op_o !== 3'd3) begin
         fails++; $display("FAIL mostra_hold got A=%h B=%h op=%0d exp 2a 15 3", a_o, b_o, op_o);
      end
      carry = 1'b0;
   endtask

   task automatic test_flag_sweep();
      logic [2:0] codes [6] = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b110, 3'b011};
      logic [3:0] exp   [6] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0010};
      for (int i = 0; i < 6; i++) begin
         press();
         tests++;
         if (estado !== 3'd0) begin fails++; $display("FAIL mostra_exit[%0d] got st=%0d exp 0", i, estado); end
         chaves = 8'(i);
         press();
         tests++;
         if (valido !== 1'b0 || {lz, lc, le, lo} !== 4'b0000) begin
            fails++; $display("FAIL clear_on_a[%0d] got v=%b leds=%b%b%b%b exp v=0 leds=0000", i, valido, lz, lc, le, lo);
         end
         press();
         ula_saida = 8'h10 + 8'(i);
         ula_flags = codes[i];
         press();
         tick();
         tests++;
         if (estado !== 3'd4 || {lz, lc, le, lo} !== exp[i] || res_o !== 8'h10 + 8'(i) || valido !== 1'b1) begin
            fails++; $display("FAIL flags[%b] got st=%0d leds=%b%b%b%b R=%h v=%b exp st=4 leds=%b R=%h v=1",
                              codes[i], estado, lz, lc, le, lo, res_o, valido, exp[i], 8'h10 + 8'(i));
         end
      end
   endtask

   task automatic test_held_button();
      press();
      chaves = 8'h77;
      botao = 1'b1;
      repeat (50) tick();
      botao = 1'b0;
      repeat (DEB + 4) tick();
      tests++;
      if (estado !== 3'd1 || a_o !== 8'h77) begin fails++; $display("FAIL held_button got st=%0d A=%h exp st=1 A=77", estado, a_o); end
   endtask

`ifndef ULA_SEQ_DEBOUNCE_EN
   task automatic test_exec_press();
      chaves = 8'h01;
      press();
      ula_saida = 8'hAB;
      ula_flags = 3'b010;
      botao = 1'b1;
      tick();
      botao = 1'b0;
      tick();
      tests++;
      if (estado !== 3'd3) begin fails++; $display("FAIL exec_press_entry got st=%0d exp 3", estado); end
      botao = 1'b1;
      tick();
      tick();
      botao = 1'b0;
      tick();
      tests++;
      if (estado !== 3'd4 || res_o !== 8'hAB || {lz, lc, le, lo} !== 4'b0100) begin
         fails++; $display("FAIL exec_press_ignored got st=%0d R=%h leds=%b%b%b%b exp st=4 R=ab leds=0100",
                           estado, res_o, lz, lc, le, lo);
      end
   endtask

   task automatic test_reset_mid_exec();
      press();
      chaves = 8'h55;
      press();
      press();
      ula_saida = 8'hCC;
      ula_flags = 3'b001;
      botao = 1'b1;
      tick();
      tick();
      tests++;
      if (estado !== 3'd3) begin fails++; $display("FAIL pre_reset_exec got st=%0d exp 3", estado); end
      botao = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (estado !== 3'd0 || {a_o, b_o, c_o, op_o, res_o, lz, lc, le, lo, valido} !== 32'h0) begin
         fails++; $display("FAIL reset_mid_exec got st=%0d A=%h B=%h R=%h v=%b exp all 0", estado, a_o, b_o, res_o, valido);
      end
      repeat (3) tick();
      tests++;
      if (estado !== 3'd0 || valido !== 1'b0 || res_o !== 8'h00) begin
         fails++; $display("FAIL no_capture_after_reset got st=%0d v=%b R=%h exp 0 0 00", estado, valido, res_o);
      end
      chaves = 8'h99;
      botao = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      tests++;
      if (estado !== 3'd0 || a_o !== 8'h00) begin fails++; $display("FAIL press_with_reset got st=%0d A=%h exp 0 00", estado, a_o); end
      botao = 1'b0;
      rst = 1'b0;
      tick();
      tick();
      tests++;
      if (estado !== 3'd0 || a_o !== 8'h00) begin fails++; $display("FAIL press_lost_after_reset got st=%0d A=%h exp 0 00", estado, a_o); end
   endtask
`else
   task automatic test_debounce();
      chaves = 8'h12;
      botao = 1'b1;
      repeat (5) tick();
      botao = 1'b0;
      repeat (30) tick();
      tests++;
      if (estado !== 3'd1 || b_o === 8'h12) begin fails++; $display("FAIL glitch got st=%0d B=%h exp st=1 B!=12", estado, b_o); end
      botao = 1'b1;
      repeat (20) tick();
      botao = 1'b0;
      repeat (30) tick();
      tests++;
      if (estado !== 3'd2 || b_o !== 8'h12) begin fails++; $display("FAIL debounced_press got st=%0d B=%h exp st=2 B=12", estado, b_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_load_capture();
      test_flag_sweep();
      test_held_button();
`ifndef ULA_SEQ_DEBOUNCE_EN
      test_exec_press();
      test_reset_mid_exec();
`else
      test_debounce();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
